// File: rtl/instr_loader.sv
// instr_loader: writer side of the self-test instruction memory.
// Takes a byte stream over valid/ready. The first byte is a header giving the
// instruction count N. The following N*WORD_BYTES bytes are packed
// little-endian into words and written to RAM port A at addresses 0..N-1.
// Optional build macro: INSTR_LOADER_CHECKSUM_EN. When defined, one extra
// trailing byte must equal the XOR of every byte accepted before it, header
// included.
module instr_loader #(
  parameter int WORD_BYTES = 7,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    in_ready,
  output logic                    wea,
  output logic [ADDR_W-1:0]       addra,
  output logic [8*WORD_BYTES-1:0] dina,
  output logic                    load_done,
  output logic [ADDR_W:0]         instr_count,
  output logic [7:0]              status
);

  localparam int DW     = 8 * WORD_BYTES;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [BIDX_W-1:0] LAST_LANE = BIDX_W'(WORD_BYTES - 1);
  localparam logic [BIDX_W-1:0] LANE_ONE  = BIDX_W'(1);
  localparam logic [ADDR_W-1:0] WIDX_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [8:0]        DEPTH_HDR = 9'(DEPTH);

  // Status codes shared with the self-test harness.
  localparam logic [7:0] STATUS_BUSY = 8'h00;
  localparam logic [7:0] STATUS_OK   = 8'h3E;
  localparam logic [7:0] STATUS_FAIL = 8'h21;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [BIDX_W-1:0] byte_idx_r;
  logic [DW-1:0]     word_buf_r;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]        xor_r;
`endif

  logic          in_ready_s;
  logic          accept_s;
  logic          hdr_bad_s;
  logic          last_byte_s;
  logic          last_word_s;
  logic [DW-1:0] word_next_s;

  // Readiness depends on state alone so the upstream source never sees a
  // combinational path from its own valid back to ready.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_LOAD, ST_CHECK: in_ready_s = 1'b1;
      default:                    in_ready_s = 1'b0;
    endcase
  end

  assign in_ready    = in_ready_s;
  assign accept_s    = in_valid & in_ready_s;
  assign hdr_bad_s   = (in_byte == 8'h00) || ({1'b0, in_byte} > DEPTH_HDR);
  assign last_byte_s = (byte_idx_r == LAST_LANE);
  assign last_word_s = ({1'b0, word_idx_r} == (instr_count - CNT_ONE));

  // Current partial word with the incoming byte merged into lane byte_idx_r.
  always_comb begin
    word_next_s = word_buf_r;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byte_idx_r == BIDX_W'(k)) begin
        word_next_s[8*k +: 8] = in_byte;
      end else begin
        word_next_s[8*k +: 8] = word_buf_r[8*k +: 8];
      end
    end
  end

  // Load sequencing: header check, word assembly, RAM write, final status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      word_idx_r  <= '0;
      byte_idx_r  <= '0;
      word_buf_r  <= '0;
      wea         <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      load_done   <= 1'b0;
      instr_count <= '0;
      status      <= STATUS_BUSY;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_r       <= 8'h00;
`endif
    end else begin
      wea <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_r <= in_byte;
`endif
            if (hdr_bad_s) begin
              state_r   <= ST_ERR;
              status    <= STATUS_FAIL;
              load_done <= 1'b0;
            end else begin
              instr_count <= (ADDR_W + 1)'(in_byte);
              word_idx_r  <= '0;
              byte_idx_r  <= '0;
              state_r     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_r <= xor_r ^ in_byte;
`endif
            if (last_byte_s) begin
              wea        <= 1'b1;
              addra      <= word_idx_r;
              dina       <= word_next_s;
              byte_idx_r <= '0;
              if (last_word_s) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                state_r   <= ST_CHECK;
`else
                state_r   <= ST_DONE;
                load_done <= 1'b1;
                status    <= STATUS_OK;
`endif
              end else begin
                // Only advanced for non-final words, so it stays within N-1.
                word_idx_r <= word_idx_r + WIDX_ONE;
              end
            end else begin
              word_buf_r <= word_next_s;
              byte_idx_r <= byte_idx_r + LANE_ONE;
            end
          end
        end
        ST_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          if (accept_s) begin
            if (in_byte == xor_r) begin
              state_r   <= ST_DONE;
              load_done <= 1'b1;
              status    <= STATUS_OK;
            end else begin
              state_r   <= ST_ERR;
              load_done <= 1'b0;
              status    <= STATUS_FAIL;
            end
          end
`else
          // Unreachable without the checksum build; fail safe if entered.
          state_r   <= ST_ERR;
          load_done <= 1'b0;
          status    <= STATUS_FAIL;
`endif
        end
        ST_DONE: begin
          state_r <= ST_DONE;
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r   <= ST_ERR;
          load_done <= 1'b0;
          status    <= STATUS_FAIL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Streams directed and random loads.
// The expected RAM image, status and count are computed from the byte stream
// by plain arithmetic. A negedge monitor collects every RAM write.
module tb_instr_loader;

  localparam int WB     = 7;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [8*WB-1:0]   dina;
  logic              load_done;
  logic [ADDR_W:0]   instr_count;
  logic [7:0]        status;

  int vectors     = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] obs_addr_q[$];
  logic [8*WB-1:0]   obs_data_q[$];
  logic [7:0]        data_q[$];

  instr_loader #(.WORD_BYTES(WB), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .wea(wea), .addra(addra), .dina(dina),
    .load_done(load_done), .instr_count(instr_count), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every RAM write away from the active edge.
  always @(negedge clk) begin
    if (wea === 1'b1) begin
      obs_addr_q.push_back(addra);
      obs_data_q.push_back(dina);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".wea"},       64'(wea),         64'd0);
    check({tag, ".addra"},     64'(addra),       64'd0);
    check({tag, ".dina"},      64'(dina),        64'd0);
    check({tag, ".load_done"}, 64'(load_done),   64'd0);
    check({tag, ".count"},     64'(instr_count), 64'd0);
    check({tag, ".status"},    64'(status),      64'h00);
    check({tag, ".in_ready"},  64'(in_ready),    64'd1);
  endtask

  // One complete load. pat_mode 0: incrementing from start_b, 1: random.
  // gap_mode 0: back-to-back, 1: drop valid every third cycle, 2: random gaps.
  task automatic do_load(input string tag, input int n, input int pat_mode,
                         input logic [7:0] start_b, input int gap_mode,
                         input bit good_ck);
    int          base;
    int          nbytes;
    bit          hdr_ok;
    logic [7:0]  ck;
    logic [8*WB-1:0] exp_w;
    logic [7:0]  exp_status;
    do_reset();
    check_reset_state({tag, ".rst"});
    base   = obs_addr_q.size();
    hdr_ok = (n >= 1) && (n <= DEPTH);
    nbytes = hdr_ok ? n * WB : 0;
    data_q.delete();
    for (int i = 0; i < nbytes; i++) begin
      if (pat_mode == 0) data_q.push_back(8'(start_b + 8'(i)));
      else               data_q.push_back(8'($urandom_range(0, 255)));
    end
    ck = 8'(n);
    foreach (data_q[i]) ck = ck ^ data_q[i];

    push(8'(n));
    for (int i = 0; i < nbytes; i++) begin
      push(data_q[i]);
      if (gap_mode == 1 && (i % 2) == 1) idle(1);
      if (gap_mode == 2) idle($urandom_range(0, 2));
    end
    if (CK_EN && hdr_ok) push(good_ck ? ck : (ck ^ 8'h01));
    // Bytes offered after the load ends must be refused.
    repeat (3) push(8'hA5);
    idle(2);

    if (!hdr_ok || (CK_EN && !good_ck)) exp_status = 8'h21;
    else                                exp_status = 8'h3E;
    check({tag, ".status"},    64'(status),    64'(exp_status));
    check({tag, ".load_done"}, 64'(load_done), (exp_status == 8'h3E) ? 64'd1 : 64'd0);
    check({tag, ".in_ready"},  64'(in_ready),  64'd0);
    if (hdr_ok) check({tag, ".count"}, 64'(instr_count), 64'(n));
    check({tag, ".writes"}, 64'(obs_addr_q.size() - base), hdr_ok ? 64'(n) : 64'd0);
    for (int w = 0; w < n && hdr_ok && (base + w) < obs_addr_q.size(); w++) begin
      exp_w = '0;
      for (int k = 0; k < WB; k++) exp_w = exp_w | ((8*WB)'(data_q[w*WB + k]) << (8*k));
      check($sformatf("%s.addr%0d", tag, w), 64'(obs_addr_q[base + w]), 64'(w));
      check($sformatf("%s.data%0d", tag, w), 64'(obs_data_q[base + w]), 64'(exp_w));
    end
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] cnt_hold;
    logic [7:0] st_hold;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("init");

    // Single word, contiguous stream 0x01..0x07.
    do_load("single", 1, 0, 8'h01, 0, 1'b1);
    // Three words with valid dropped every third cycle.
    do_load("gapped", 3, 0, 8'h10, 1, 1'b1);
    // Header bounds.
    do_load("hdr0",   0,  0, 8'h00, 0, 1'b1);
    do_load("hdr65",  65, 0, 8'h00, 0, 1'b1);
    do_load("hdr64",  64, 1, 8'h00, 0, 1'b1);

    // Reset mid-load, with reset coincident with a valid byte.
    do_reset();
    base = obs_addr_q.size();
    push(8'h02);
    for (int i = 0; i < 4; i++) push(8'(8'h30 + 8'(i)));
    in_valid = 1'b1;
    in_byte  = 8'h77;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check_reset_state("midrst");
    idle(3);
    check("midrst.writes", 64'(obs_addr_q.size() - base), 64'd0);
    do_load("fresh", 1, 1, 8'h00, 0, 1'b1);

    // Refusal after done: hold valid with bytes for many cycles.
    base     = obs_addr_q.size();
    cnt_hold = 8'(instr_count);
    st_hold  = status;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_byte = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    idle(1);
    check("refuse.in_ready", 64'(in_ready), 64'd0);
    check("refuse.writes",   64'(obs_addr_q.size() - base), 64'd0);
    check("refuse.count",    64'(instr_count), 64'd1);
    check("refuse.count_hold", 64'(instr_count), 64'(cnt_hold));
    check("refuse.status",   64'(status), 64'h3E);
    check("refuse.status_hold", 64'(status), 64'(st_hold));

    // Checksum-specific directed cases (ordinary loads without the macro).
    do_load("ck_good", 1, 0, 8'h01, 0, 1'b1);
    do_load("ck_bad",  1, 0, 8'h01, 0, 1'b0);

    // Random loads.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 20);
      do_load($sformatf("rnd%0d", t), n, 1, 8'h00, 2, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the self-test instruction memory. The self-test harness reads 56-bit instruction words from block RAM port A by address; this block fills that RAM.
- Accepts a byte stream over a valid/ready handshake and assembles 7-byte instruction words. Writes each word to the RAM at consecutive addresses starting at 0.
- Reports the loaded instruction count and a status byte, using the same success code the harness already uses.

Parameters:
- WORD_BYTES, 7, bytes per instruction word; dina width = 8*WORD_BYTES.
- ADDR_W, 6, RAM address width.
- DEPTH, 64, maximum instruction count; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_byte is valid this cycle.
- in_byte  in  8  stream byte.
- in_ready  out  1  block accepts a byte this cycle.
- wea  out  1  RAM write enable, one-cycle pulse per word.
- addra  out  ADDR_W  RAM write address.
- dina  out  8*WORD_BYTES  RAM write data.
- load_done  out  1  load completed successfully; sticky.
- instr_count  out  ADDR_W+1  header count N; the harness upper bound.
- status  out  8  0x00 busy, 0x3E success, 0x21 error.

Behaviour:
- Reset (synchronous, active-high, at a clk edge with rst=1):
  - state=IDLE; wea=0, addra=0, dina=0, load_done=0, instr_count=0, status=0x00.
  - Partial word and byte index are cleared. RAM contents are not cleared.
- Transfer rule: a byte is accepted only on a clk edge where in_valid=1 and in_ready=1. Nothing is consumed in any other cycle. in_byte is don't-care when in_valid=0.
- in_ready = 1 in IDLE, LOAD and CHECK; 0 in DONE and ERR. Driven combinationally from state only; never from in_valid.
- IDLE:
  - The first accepted byte is the header N.
  - N=0 or N>DEPTH -> ERR.
  - Otherwise instr_count<=N, word index w=0, byte index b=0 -> LOAD.
- LOAD:
  - Each accepted byte fills byte lane b of the word, little-endian: the byte with b=0 lands in dina[7:0], b=WORD_BYTES-1 lands in the top lane.
  - On the edge accepting byte b=WORD_BYTES-1, the following are registered together:
    - wea<=1
    - addra<=w
    - dina<= the completed word
  - wea is high for exactly the next cycle, then returns to 0. addra and dina hold their values until the next write.
  - Back-to-back bytes are accepted during the wea cycle, so sustained throughput is 1 byte/clk.
  - After a word write: w<=w+1, b<=0.
  - If w=N-1, the next state is DONE (or CHECK when CHECKSUM_EN is defined) on the same edge.
- DONE: load_done=1, status=0x3E. Holds until rst; further bytes are refused.
- ERR: load_done=0, status=0x21, wea never asserted. Holds until rst.
- status stays 0x00 in IDLE, LOAD and CHECK.
- Width rules:
  - w counts 0..N-1 and never wraps past DEPTH-1.
  - instr_count is wide enough to hold DEPTH=64 exactly.
- Reset mid-load: a partial word is discarded and no write is issued. RAM words already written remain in the RAM, but the load is reported as not done.
- rst coincident with a valid byte: reset wins and the byte is not accepted.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR is kept over all accepted bytes, header included.
  - After the last data word, state=CHECK and exactly one more byte is accepted.
  - That byte equals the running XOR -> DONE. Otherwise -> ERR with status 0x21 and load_done=0.
  - Words already written stay in RAM.
- Undefined: no CHECK state, no XOR register; LOAD goes directly to DONE after word N-1.

Test Plan:
- Single word:
  - Stream 0x01, 0x01..0x07 with in_valid held high -> one wea pulse, addra=0, dina=0x07060504030201.
  - Next cycle load_done=1, status=0x3E, instr_count=1, in_ready=0.
- Gapped stream:
  - N=3, 21 data bytes 0x10..0x24 with in_valid dropped every third cycle.
  - -> exactly 3 wea pulses: addra 0, 1, 2 with dina 0x16151413121110, 0x1D1C1B1A191817, 0x24232221201F1E.
  - No wea during gaps; DONE after the third write.
- Header bounds: N=0x00 -> ERR, status=0x21, no wea. After rst, N=0x41 (65) -> ERR. After rst, N=0x40 with 448 bytes -> 64 writes, addra 0..63, DONE.
- Reset mid-load:
  - N=2, rst after the 4th byte of word 0 -> no wea, outputs back to reset values.
  - Fresh N=1 load -> write at addra=0, DONE.
- Refusal after done: hold in_valid=1 with bytes in DONE -> in_ready=0, no wea, instr_count and status unchanged.
- INSTR_LOADER_CHECKSUM_EN:
  - N=1, bytes 0x01..0x07, checksum 0x01^0x01^…^0x07=0x01 -> DONE.
  - Same stream with checksum 0x00 -> ERR, status=0x21, load_done=0, RAM word 0 written once.
